// File: rtl/i_cache_assoc.sv
// N-way set-associative read-only instruction cache with round-robin victim selection,
// whole-cache flush and optional branch decode (macro I_CACHE_BRANCH_DETECT_EN).
module i_cache_assoc #(
  parameter int DATA_WIDTH         = 32,
  parameter int TAG_WIDTH          = 14,
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2,
  parameter int WAYS               = 2
) (
  input  logic                                                  i_Clk,
  input  logic                                                  i_Reset,
  input  logic                                                  i_Valid,
  input  logic [TAG_WIDTH+INDEX_WIDTH+BLOCK_OFFSET_WIDTH-1:0]   i_Address,
  input  logic                                                  i_Flush,
  output logic                                                  o_MEM_Valid,
  output logic [TAG_WIDTH+INDEX_WIDTH+BLOCK_OFFSET_WIDTH-1:0]   o_MEM_Address,
  input  logic                                                  i_MEM_Valid,
  input  logic                                                  i_MEM_Last,
  input  logic [DATA_WIDTH-1:0]                                 i_MEM_Data,
  output logic                                                  o_Ready,
  output logic                                                  o_Valid,
  output logic [DATA_WIDTH-1:0]                                 o_Data,
  output logic                                                  o_IsBranch
);

  localparam int BO    = BLOCK_OFFSET_WIDTH;
  localparam int AW    = TAG_WIDTH + INDEX_WIDTH + BO;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << BO;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [BO:0]            BEAT_LAST = (BO+1)'(WORDS - 1);
  localparam logic [INDEX_WIDTH-1:0] SET_LAST  = INDEX_WIDTH'(SETS - 1);

  typedef enum logic [1:0] {READY, MISS, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    missTag_q, missTag_d;
  logic [INDEX_WIDTH-1:0]  missIndex_q, missIndex_d;
  logic [BO-1:0]           missOffset_q, missOffset_d;
  logic [BO:0]             beat_q, beat_d;
  logic [WAY_W-1:0]        victim_q, victim_d;
  logic                    flushPend_q, flushPend_d;
  logic [INDEX_WIDTH-1:0]  flushIdx_q, flushIdx_d;

  logic [SETS-1:0][WAYS-1:0]  validSet_q;
  logic [SETS-1:0][WAY_W-1:0] rrPtr_q;
  logic [TAG_WIDTH-1:0]       tagMem_q  [WAYS][SETS];
  logic [DATA_WIDTH-1:0]      dataMem_q [WAYS][SETS][WORDS];

  logic [TAG_WIDTH-1:0]   reqTag;
  logic [INDEX_WIDTH-1:0] reqIndex;
  logic [BO-1:0]          reqOffset;
  logic [WAYS-1:0]        hitVec;
  logic [DATA_WIDTH-1:0]  hitWord;
  logic                   hitOne;
  logic                   freeFound;
  logic [WAY_W-1:0]       freeWay, victimSel, nextPtr;
  logic                   rspValid, fillWrite, fillCommit, fillAbort, flushClear;
  logic [DATA_WIDTH-1:0]  rspData;

  assign reqTag    = i_Address[AW-1 -: TAG_WIDTH];
  assign reqIndex  = i_Address[BO +: INDEX_WIDTH];
  assign reqOffset = i_Address[BO-1:0];

  always_comb begin
    hitVec  = '0;
    hitWord = '0;
    for (int w = 0; w < WAYS; w++) begin
      hitVec[w] = validSet_q[reqIndex][w] && (tagMem_q[w][reqIndex] == reqTag);
      if (hitVec[w]) hitWord = hitWord | dataMem_q[w][reqIndex][reqOffset];
    end
  end

  // A set only counts as hit when exactly one way matches.
  assign hitOne = (hitVec != '0) && ((hitVec & (hitVec - WAYS'(1))) == '0);

  always_comb begin
    freeFound = 1'b0;
    freeWay   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validSet_q[reqIndex][w]) begin
        freeFound = 1'b1;
        freeWay   = WAY_W'(w);
      end
    end
  end

  assign victimSel = freeFound ? freeWay : rrPtr_q[reqIndex];
  assign nextPtr   = (WAYS == 1) ? '0 : rrPtr_q[missIndex_q] + WAY_W'(1);

  always_comb begin
    state_d      = state_q;
    missTag_d    = missTag_q;
    missIndex_d  = missIndex_q;
    missOffset_d = missOffset_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    flushPend_d  = flushPend_q;
    flushIdx_d   = flushIdx_q;
    rspValid     = 1'b0;
    rspData      = '0;
    fillWrite    = 1'b0;
    fillCommit   = 1'b0;
    fillAbort    = 1'b0;
    flushClear   = 1'b0;
    case (state_q)
      READY: begin
        if (i_Flush) begin
          flushIdx_d = '0;
          state_d    = FLUSH;
        end else if (i_Valid) begin
          if (hitOne) begin
            rspValid = 1'b1;
            rspData  = hitWord;
          end else begin
            missTag_d    = reqTag;
            missIndex_d  = reqIndex;
            missOffset_d = reqOffset;
            beat_d       = '0;
            victim_d     = victimSel;
            flushPend_d  = 1'b0;
            state_d      = MISS;
          end
        end
      end
      MISS: begin
        if (i_Flush) flushPend_d = 1'b1;
        if (i_MEM_Valid) begin
          if (beat_q <= BEAT_LAST) begin
            fillWrite = 1'b1;
            beat_d    = beat_q + (BO+1)'(1);
          end
          if (beat_q == {1'b0, missOffset_q}) begin
            rspValid = 1'b1;
            rspData  = i_MEM_Data;
          end
          // A truncated fill leaves the victim invalid so stale tags never match partial data.
          if (i_MEM_Last) begin
            fillCommit = (beat_q == BEAT_LAST);
            fillAbort  = (beat_q != BEAT_LAST);
            flushIdx_d = '0;
            state_d    = (flushPend_q || i_Flush) ? FLUSH : READY;
          end
        end
      end
      FLUSH: begin
        flushClear = 1'b1;
        flushIdx_d = flushIdx_q + INDEX_WIDTH'(1);
        if (flushIdx_q == SET_LAST) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= READY;
      missTag_q    <= '0;
      missIndex_q  <= '0;
      missOffset_q <= '0;
      beat_q       <= '0;
      victim_q     <= '0;
      flushPend_q  <= 1'b0;
      flushIdx_q   <= '0;
    end else begin
      state_q      <= state_d;
      missTag_q    <= missTag_d;
      missIndex_q  <= missIndex_d;
      missOffset_q <= missOffset_d;
      beat_q       <= beat_d;
      victim_q     <= victim_d;
      flushPend_q  <= flushPend_d;
      flushIdx_q   <= flushIdx_d;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      validSet_q <= '0;
      rrPtr_q    <= '0;
    end else begin
      if (fillCommit) begin
        validSet_q[missIndex_q][victim_q] <= 1'b1;
        rrPtr_q[missIndex_q]              <= nextPtr;
      end
      if (fillAbort)  validSet_q[missIndex_q][victim_q] <= 1'b0;
      if (flushClear) validSet_q[flushIdx_q] <= '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (fillWrite)  dataMem_q[victim_q][missIndex_q][beat_q[BO-1:0]] <= i_MEM_Data;
    if (fillCommit) tagMem_q[victim_q][missIndex_q] <= missTag_q;
  end

  assign o_Ready       = (state_q == READY);
  assign o_MEM_Valid   = (state_q == MISS);
  assign o_MEM_Address = {missTag_q, missIndex_q, {BO{1'b0}}};
  assign o_Valid       = rspValid;
  assign o_Data        = rspData;

`ifdef I_CACHE_BRANCH_DETECT_EN
  assign o_IsBranch = rspValid & (rspData[31:29] == 3'b000) & (rspData[27:26] != 2'b11);
`else
  assign o_IsBranch = 1'b0;
`endif

endmodule

// File: doc/i_cache_assoc.md
# i_cache_assoc

Parametrised N-way set-associative, read-only instruction cache sitting between the fetch stage and instruction memory. It generalises the direct-mapped instruction cache with configurable associativity and line length, and adds victim selection and a whole-cache flush. Hits return combinationally in the request cycle. Misses fill a full line from memory and forward the requested word the cycle it arrives.

## Interface
- DATA_WIDTH, 32, instruction word width
- TAG_WIDTH, 14, tag bits
- INDEX_WIDTH, 5, set index bits (2^INDEX_WIDTH sets)
- BLOCK_OFFSET_WIDTH, 2, word offset bits (2^BLOCK_OFFSET_WIDTH words per line)
- WAYS, 2, associativity, power of two, 1..8; WAY_W = max(1, log2(WAYS))
- i_Clk  in  1  clock; all state updates on rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Valid  in  1  fetch request valid
- i_Address  in  AW = TAG_WIDTH+INDEX_WIDTH+BLOCK_OFFSET_WIDTH  word address {tag, index, offset}
- i_Flush  in  1  pulse: invalidate every line
- o_MEM_Valid  out  1  line-fill request active
- o_MEM_Address  out  AW  line-aligned fill address {tag, index, 0}
- i_MEM_Valid  in  1  fill beat valid
- i_MEM_Last  in  1  final fill beat
- i_MEM_Data  in  DATA_WIDTH  fill beat data, words in offset order 0, 1, 2, …
- o_Ready  out  1  cache is in READY and accepts requests
- o_Valid  out  1  o_Data holds the requested word
- o_Data  out  DATA_WIDTH  requested word; 0 when o_Valid is 0
- o_IsBranch  out  1  branch classification of o_Data (see Configuration)

## Operation
- States: READY, MISS, FLUSH. Reset puts the block in READY and clears every valid bit and every round-robin pointer.
- Outputs under reset: o_Valid, o_MEM_Valid, o_IsBranch = 0; o_Data and o_MEM_Address = 0; o_Ready = 1.
- READY, i_Valid, i_Flush low:
  - Look up all ways of the set in parallel.
  - Hit when exactly one way is valid with a matching tag: o_Valid = 1 and o_Data = word[offset] of that way, in the same cycle.
  - Miss: latch tag, index and offset, clear the beat counter, go to MISS.
- Victim choice, made at miss time: the lowest-numbered invalid way; if all ways are valid, the set's round-robin pointer. WAYS = 1 always uses way 0.
- MISS:
  - o_MEM_Valid = 1, with o_MEM_Address held constant throughout.
  - Each i_MEM_Valid beat writes word[beat] of the victim, then beat increments.
  - Beats beyond 2^BLOCK_OFFSET_WIDTH-1 are ignored.
  - When beat == latched offset: o_Valid = 1 and o_Data = i_MEM_Data in the same cycle.
  - i_MEM_Valid with i_MEM_Last:
    - If beat == 2^BLOCK_OFFSET_WIDTH-1: write the tag, set the valid bit, advance the set's pointer modulo WAYS.
    - If i_MEM_Last comes early: leave the line invalid.
    - Either way, return to READY.
  - i_Valid is ignored in MISS.
- i_Flush:
  - In READY it has priority over i_Valid: o_Valid is 0 that cycle, and the block goes to FLUSH.
  - During MISS it is latched, and FLUSH is entered after the fill completes instead of READY.
- FLUSH: clear the valid bits of one set per cycle (all ways), sets 0 to 2^INDEX_WIDTH-1, then return to READY. Pointers are untouched.
- Reset mid-MISS or mid-FLUSH: immediate return to READY with all lines invalid; o_MEM_Valid drops asynchronously.

## Timing
- Hit latency: 0 cycles, combinational from i_Address to o_Data/o_Valid.
- Miss: detected in cycle T; o_Ready = 0 and o_MEM_Valid = 1 from T+1.
  - Requested word appears on the cycle its beat arrives.
  - With i_MEM_Last in cycle L, o_Ready = 1 at L+1, and re-requesting the address at L+1 hits.
- Flush requested in cycle T: o_Ready = 0 for cycles T+1 … T+2^INDEX_WIDTH, and 1 at T+2^INDEX_WIDTH+1.
- o_Ready = (state == READY), decoded from the registered state.

## Configuration
- I_CACHE_BRANCH_DETECT_EN defined: o_IsBranch = o_Valid & (o_Data[31:29] == 3'b000) & (o_Data[27:26] != 2'b11). The decode is combinational on the same-cycle o_Data.
- Not defined: o_IsBranch is tied to 0 and no decode logic is built.

## Test plan
- Cold miss with WAYS=2, offset 2 at address 0x00A6:
  - Stimulus: fill beats 0x11, 0x22, 0x33, 0x44, with Last on the 4th.
  - Required: o_MEM_Address = 0x00A4; o_Valid with 0x33 on beat 3; re-request hits with 0x33 at 0 latency.
- Two tags in one set:
  - Stimulus: tags 1 and 2 at index 3, both filled; then tag 3 at index 3.
  - Required: tags 1 and 2 both hit afterwards; tag 3 evicts way 0 (tag 1) and leaves tag 2 resident; a further tag-4 miss evicts way 1.
- Flush:
  - Stimulus: i_Flush after filling 3 lines (INDEX_WIDTH=5).
  - Required: o_Ready low for exactly 32 cycles; all 3 addresses then miss.
- Flush during fill:
  - Stimulus: i_Flush asserted at beat 1 of a fill.
  - Required: the fill completes, FLUSH follows, and the filled line misses afterwards.
- Early i_MEM_Last on beat 2:
  - Required: the line stays invalid and the next request to it misses.
- Reset asserted mid-fill:
  - Required: o_MEM_Valid = 0 immediately, o_Ready = 1, and every prior line misses.
- With I_CACHE_BRANCH_DETECT_EN defined:
  - Hit on 0x10850003 (beq) gives o_IsBranch = 1.
  - Hit on 0x8C850000 (lw) gives o_IsBranch = 0.
